// File: rtl/encoder8x3_irq.sv
// Registered 8-to-3 priority encoder: active-low request lines are edge-captured into
// pending bits and granted highest-index-first over a VALID/ACK handshake. ENC_SYNC_EN adds a 2-flop IL synchronizer.
module encoder8x3_irq (
  input  logic       CLK,
  input  logic       RST_L,
  input  logic       EN,
  input  logic [7:0] IL,
  input  logic       ACK,
  output logic [2:0] DOUT,
  output logic       VALID,
  output logic       GSL
);
  localparam int NUM_LANES = 8;
  localparam int IDX_W     = 3;

  typedef enum logic {IDLE, HOLD} state_t;

  logic [NUM_LANES-1:0] il_s;
  logic [NUM_LANES-1:0] il_q;
  logic [NUM_LANES-1:0] pend_q, pend_d;
  logic [NUM_LANES-1:0] fall, clr;
  logic                 cap_en;

`ifdef ENC_SYNC_EN
  localparam int ARM = 3;
  logic [NUM_LANES-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= IL;
      sync2_q <= sync1_q;
    end
  end

  assign il_s = sync2_q;
`else
  localparam int ARM = 1;
  assign il_s = IL;
`endif

  // Capture is held off until the history path has seen a real sample of IL, so a
  // line already low when reset releases is not mistaken for a fresh request.
  logic [ARM-1:0] arm_q, arm_d;
  assign arm_d  = ARM'({arm_q, 1'b1});
  assign cap_en = arm_q[ARM-1];

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) arm_q <= '0;
    else        arm_q <= arm_d;
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             gsl_q, gsl_d;

  // Only a HOLD-state acknowledge retires the presented bit.
  assign clr = (state_q == HOLD && ACK) ? (NUM_LANES'(1) << dout_q) : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign fall[i]   = cap_en & il_q[i] & ~il_s[i];
    assign pend_d[i] = fall[i] | (pend_q[i] & ~clr[i]);
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      il_q   <= '1;
      pend_q <= '0;
    end else begin
      il_q   <= il_s;
      pend_q <= pend_d;
    end
  end

  function automatic logic [IDX_W-1:0] hi_idx(input logic [NUM_LANES-1:0] v);
    hi_idx = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (v[i]) hi_idx = IDX_W'(i);
  endfunction

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (EN && |pend_q) begin
          dout_d  = hi_idx(pend_q);
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ACK) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    gsl_d = ~(EN & |pend_d);
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q <= IDLE;
      dout_q  <= '0;
      valid_q <= 1'b0;
      gsl_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      gsl_q   <= gsl_d;
    end
  end

  assign DOUT  = dout_q;
  assign VALID = valid_q;
  assign GSL   = gsl_q;

endmodule

// File: tb/tb_encoder8x3_irq.sv
// Bench for encoder8x3_irq: directed vector table, reset corner cases, then random
// stimulus against a request-set reference model.
module tb_encoder8x3_irq;
  logic       CLK = 1'b0;
  logic       RST_L = 1'b0;
  logic       EN = 1'b1;
  logic [7:0] IL = 8'h00;
  logic       ACK = 1'b1;
  logic [2:0] DOUT;
  logic       VALID;
  logic       GSL;

  int n_chk  = 0;
  int n_fail = 0;

  encoder8x3_irq dut (
    .CLK(CLK), .RST_L(RST_L), .EN(EN), .IL(IL), .ACK(ACK),
    .DOUT(DOUT), .VALID(VALID), .GSL(GSL)
  );

  always #5 CLK = ~CLK;

`ifdef ENC_SYNC_EN
  localparam int SYNC  = 1;
  localparam int ARM_N = 3;
`else
  localparam int SYNC  = 0;
  localparam int ARM_N = 1;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [2:0] d, input logic g);
    chk({name, ".VALID"}, int'(VALID), int'(v));
    chk({name, ".DOUT"},  int'(DOUT),  int'(d));
    chk({name, ".GSL"},   int'(GSL),   int'(g));
  endtask

  // Reference model: a set of pending request indices, a granted flag and index.
  bit         m_pend [8];
  logic [7:0] m_prev;
  logic [7:0] m_h0, m_h1;
  int         m_arm;
  bit         m_v;
  int         m_d;
  bit         m_g;

  function automatic bit m_any();
    for (int i = 0; i < 8; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_prev = 8'hFF; m_h0 = 8'hFF; m_h1 = 8'hFF;
    m_arm = ARM_N; m_v = 1'b0; m_d = 0; m_g = 1'b1;
  endtask

  task automatic m_step(input logic en, input logic [7:0] il, input logic ack);
    logic [7:0] eff;
    bit fell [8];
    eff = il;
    if (SYNC != 0) begin
      eff  = m_h1;
      m_h1 = m_h0;
      m_h0 = il;
    end
    for (int i = 0; i < 8; i++) fell[i] = (m_arm == 0) && m_prev[i] && !eff[i];
    if (m_arm > 0) m_arm--;
    m_prev = eff;
    if (m_v) begin
      if (ack) begin
        if (!fell[m_d]) m_pend[m_d] = 1'b0;
        m_v = 1'b0;
      end
    end else if (en && m_any()) begin
      for (int i = 7; i >= 0; i--)
        if (m_pend[i]) begin m_d = i; break; end
      m_v = 1'b1;
    end
    for (int i = 0; i < 8; i++) if (fell[i]) m_pend[i] = 1'b1;
    m_g = !(en && m_any());
  endtask

  typedef struct {
    logic       en;
    logic [7:0] il;
    logic       ack;
    logic       v;
    logic [2:0] d;
    logic       g;
  } vec_t;

  vec_t tv [35];

  initial begin
    tv[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};
    tv[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};
    tv[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1};
    tv[3]  = '{1'b1, 8'hF7, 1'b0, 1'b0, 3'd0, 1'b0};  // single request idx 3
    tv[4]  = '{1'b1, 8'hF7, 1'b0, 1'b1, 3'd3, 1'b0};
    tv[5]  = '{1'b1, 8'hF7, 1'b1, 1'b0, 3'd3, 1'b1};
    tv[6]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd3, 1'b1};
    tv[7]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 3'd3, 1'b0};  // requests 7,5,2,0 at once
    tv[8]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 3'd7, 1'b0};
    tv[9]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 3'd7, 1'b0};
    tv[10] = '{1'b1, 8'h5A, 1'b0, 1'b1, 3'd5, 1'b0};
    tv[11] = '{1'b1, 8'h5A, 1'b1, 1'b0, 3'd5, 1'b0};
    tv[12] = '{1'b1, 8'h5A, 1'b0, 1'b1, 3'd2, 1'b0};
    tv[13] = '{1'b1, 8'h5A, 1'b1, 1'b0, 3'd2, 1'b0};
    tv[14] = '{1'b1, 8'h5A, 1'b0, 1'b1, 3'd0, 1'b0};
    tv[15] = '{1'b1, 8'h5A, 1'b1, 1'b0, 3'd0, 1'b1};
    tv[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1};
    tv[17] = '{1'b1, 8'hFD, 1'b0, 1'b0, 3'd0, 1'b0};  // grant 1, then 6 falls
    tv[18] = '{1'b1, 8'hFD, 1'b0, 1'b1, 3'd1, 1'b0};
    tv[19] = '{1'b1, 8'hBD, 1'b0, 1'b1, 3'd1, 1'b0};
    tv[20] = '{1'b1, 8'hBD, 1'b0, 1'b1, 3'd1, 1'b0};
    tv[21] = '{1'b1, 8'hBD, 1'b1, 1'b0, 3'd1, 1'b0};
    tv[22] = '{1'b1, 8'hBD, 1'b0, 1'b1, 3'd6, 1'b0};
    tv[23] = '{1'b1, 8'hBD, 1'b1, 1'b0, 3'd6, 1'b1};
    tv[24] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd6, 1'b1};
    tv[25] = '{1'b0, 8'hEF, 1'b0, 1'b0, 3'd6, 1'b1};  // EN low, idx 4 captured
    tv[26] = '{1'b0, 8'hEF, 1'b0, 1'b0, 3'd6, 1'b1};
    tv[27] = '{1'b1, 8'hEF, 1'b0, 1'b1, 3'd4, 1'b0};
    tv[28] = '{1'b1, 8'hEF, 1'b1, 1'b0, 3'd4, 1'b1};
    tv[29] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd4, 1'b1};
    tv[30] = '{1'b1, 8'hFB, 1'b0, 1'b0, 3'd4, 1'b0};  // ACK collides with refall
    tv[31] = '{1'b1, 8'hFB, 1'b0, 1'b1, 3'd2, 1'b0};
    tv[32] = '{1'b1, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b0};
    tv[33] = '{1'b1, 8'hFB, 1'b1, 1'b0, 3'd2, 1'b0};
    tv[34] = '{1'b1, 8'hFB, 1'b0, 1'b1, 3'd2, 1'b0};
  end

  task automatic tick_model();
    @(posedge CLK);
    m_step(EN, IL, ACK);
    #1;
    chk("rand.VALID", int'(VALID), int'(m_v));
    chk("rand.GSL",   int'(GSL),   int'(m_g));
    chk("rand.DOUT",  int'(DOUT),  m_d);
  endtask

  logic [7:0] il_r;

  initial begin
    // Reset held with IL low and ACK high.
    RST_L = 1'b0; EN = 1'b1; IL = 8'h00; ACK = 1'b1;
    #23;
    chk_out("reset", 1'b0, 3'd0, 1'b1);
    RST_L = 1'b1;

`ifndef ENC_SYNC_EN
    for (int r = 0; r < 35; r++) begin
      EN = tv[r].en; IL = tv[r].il; ACK = tv[r].ack;
      @(posedge CLK); #1;
      chk_out($sformatf("vec%0d", r), tv[r].v, tv[r].d, tv[r].g);
    end
    // Reset while VALID=1 takes effect without a clock edge.
    #2; RST_L = 1'b0; #1;
    chk_out("midrst", 1'b0, 3'd0, 1'b1);
    #2; RST_L = 1'b1;
    ACK = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk_out("postrst", 1'b0, 3'd0, 1'b1);
    end
`endif

    // Random phase against the model, with occasional async resets.
    @(negedge CLK); RST_L = 1'b0; #2; RST_L = 1'b1;
    m_reset();
    il_r = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) il_r = il_r ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) il_r = 8'($urandom);
      IL  = il_r;
      ACK = ($urandom_range(0, 2) == 0);
      EN  = ($urandom_range(0, 7) != 0);
      tick_model();
      if ($urandom_range(0, 499) == 0) begin
        #1; RST_L = 1'b0; #1;
        m_reset();
        chk("rand.rst.VALID", int'(VALID), 0);
        chk("rand.rst.GSL",   int'(GSL),   1);
        #1; RST_L = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
